// File: rtl/midi_byte_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | midi_byte_arbiter: shares the sequencer byte-trigger path between live MIDI, |
// | sysex patch dump and auto sysex sources.           Revision: 1.0            |
// +-----------------------------------------------------------------------------+
module midi_byte_arbiter #(
   parameter int GAP        = 4,
   parameter int TIMEOUT    = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       reg_clk,
   input  logic       reset_reg_N,
   input  logic       live_valid,
   input  logic [7:0] live_data,
   input  logic       patch_req,
   input  logic [7:0] patch_data,
   input  logic       patch_last,
   output logic       patch_ack,
   input  logic       auto_req,
   input  logic [7:0] auto_data,
   input  logic       auto_last,
   output logic       auto_ack,
   input  logic       clr_err,
   output logic       byteready,
   output logic [7:0] midi_in_data,
   output logic [7:0] midibyte_nr,
   output logic       dec_sysex_data_patch_send,
   output logic       auto_syx_cmd,
   output logic       busy,
   output logic       live_ovf,
   output logic       lock_timeout
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_GAP   = 2'd2;

   localparam int              c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0]   c_FULL     = FIFO_DEPTH[c_AW:0];
   localparam logic [c_AW:0]   c_CNT_ONE  = 1;
   localparam logic [c_AW-1:0] c_PTR_ONE  = 1;
   localparam logic [3:0]      c_GAP_LAST = 4'(GAP - 2);
   localparam logic [15:0]     c_TO_LAST  = 16'(TIMEOUT - 1);

   logic [1:0]      r_state;
   logic [3:0]      r_gap_cnt;
   logic [15:0]     r_to_cnt;
   logic            r_lock;
   logic            r_patch_own;
   logic            r_auto_own;
   logic            r_byteready;
   logic            r_patch_ack;
   logic            r_auto_ack;
   logic [7:0]      r_data;
   logic [7:0]      r_nr;
   logic            r_live_ovf;
   logic            r_lock_to;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   logic            w_arb;
   logic            w_el_live;
   logic            w_el_patch;
   logic            w_el_auto;
   logic            w_win_live;
   logic            w_win_patch;
   logic            w_win_auto;
   logic            w_issue;
   logic            w_stall;
   logic            w_timeout;
   logic            w_full;
   logic            w_push;
   logic            w_drop;
   logic [7:0]      w_sel_data;
   logic [7:0]      w_next_nr;

   // Arbitration happens in IDLE and in the final GAP cycle only.
   always_comb begin
      w_arb       = (r_state == c_IDLE) || ((r_state == c_GAP) && (r_gap_cnt == c_GAP_LAST));
      w_el_live   = !r_lock && (r_count != '0);
      w_el_patch  = patch_req && (!r_lock || r_patch_own);
      w_el_auto   = auto_req && (!r_lock || r_auto_own);
      w_win_live  = w_arb && w_el_live;
      w_win_patch = w_arb && !w_el_live && w_el_patch;
      w_win_auto  = w_arb && !w_el_live && !w_el_patch && w_el_auto;
      w_issue     = w_win_live || w_win_patch || w_win_auto;
      w_stall     = w_arb && r_lock && !w_issue;
      w_timeout   = w_stall && (r_to_cnt == c_TO_LAST);
      w_full      = (r_count == c_FULL);
      w_push      = live_valid && (!w_full || w_win_live);
      w_drop      = live_valid && w_full && !w_win_live;
      w_sel_data  = w_win_live ? r_mem[r_rd_ptr] : (w_win_patch ? patch_data : auto_data);
      w_next_nr   = w_sel_data[7] ? 8'd0 : ((r_nr == 8'hFF) ? 8'hFF : r_nr + 8'd1);
   end

   always_ff @(posedge reg_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= live_data;
      end
   end

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_win_live) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push && !w_win_live) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (!w_push && w_win_live) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_state     <= c_IDLE;
         r_gap_cnt   <= '0;
         r_to_cnt    <= '0;
         r_lock      <= 1'b0;
         r_patch_own <= 1'b0;
         r_auto_own  <= 1'b0;
         r_byteready <= 1'b0;
         r_patch_ack <= 1'b0;
         r_auto_ack  <= 1'b0;
         r_data      <= '0;
         r_nr        <= '0;
      end else begin
         r_byteready <= 1'b0;
         r_patch_ack <= 1'b0;
         r_auto_ack  <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_issue) begin
                  r_state <= c_ISSUE;
               end
            end
            c_ISSUE: begin
               r_state   <= c_GAP;
               r_gap_cnt <= '0;
            end
            c_GAP: begin
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_state <= w_issue ? c_ISSUE : c_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 4'd1;
               end
            end
            default: r_state <= c_IDLE;
         endcase
         // A final byte drops the lock at issue; its owner flag lingers until the GAP ends.
         if (w_issue) begin
            r_byteready <= 1'b1;
            r_data      <= w_sel_data;
            r_nr        <= w_next_nr;
            r_patch_ack <= w_win_patch;
            r_auto_ack  <= w_win_auto;
            r_patch_own <= w_win_patch;
            r_auto_own  <= w_win_auto;
            r_lock      <= (w_win_patch && !patch_last) || (w_win_auto && !auto_last);
            r_to_cnt    <= '0;
         end else if (w_timeout) begin
            r_lock      <= 1'b0;
            r_patch_own <= 1'b0;
            r_auto_own  <= 1'b0;
            r_to_cnt    <= '0;
         end else if (w_stall) begin
            r_to_cnt <= r_to_cnt + 16'd1;
         end else if (w_arb && !r_lock) begin
            r_patch_own <= 1'b0;
            r_auto_own  <= 1'b0;
         end
      end
   end

   always_ff @(posedge reg_clk or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         r_live_ovf <= 1'b0;
         r_lock_to  <= 1'b0;
      end else begin
         r_live_ovf <= (r_live_ovf && !clr_err) || w_drop;
         r_lock_to  <= (r_lock_to && !clr_err) || w_timeout;
      end
   end

   assign byteready                 = r_byteready;
   assign patch_ack                 = r_patch_ack;
   assign auto_ack                  = r_auto_ack;
   assign midi_in_data              = r_data;
   assign midibyte_nr               = r_nr;
   assign dec_sysex_data_patch_send = r_patch_own;
   assign auto_syx_cmd              = r_auto_own;
   assign busy                      = (r_state != c_IDLE) || (r_count != '0);
   assign live_ovf                  = r_live_ovf;
   assign lock_timeout              = r_lock_to;

endmodule
`default_nettype wire

// File: doc/midi_byte_arbiter.md
# midi_byte_arbiter

Shares the sequencer byte-trigger path between three MIDI byte sources: live MIDI input, sysex patch dump, and auto sysex command generator. Issues one byte at a time as a `byteready` pulse with `midi_in_data` and `midibyte_nr`. The minimum spacing between pulses covers the downstream trigger and data_ready pipeline. Sysex owners hold the path for a whole message, with a timeout. Sits between the MIDI decoder/sysex engines and the sequencer trigger stage, and drives its `dec_sysex_data_patch_send`/`auto_syx_cmd` qualifiers.

## Interface
- GAP, 4, cycles between consecutive `byteready` pulses; legal 4..15.
- TIMEOUT, 1024, idle cycles a locked owner may stall before its lock is revoked; legal 2..65535.
- FIFO_DEPTH, 4, live byte FIFO entries; power of two, 2..16.

- reg_clk  in  1  clock.
- reset_reg_N  in  1  reset, asynchronous, active-low.
- live_valid  in  1  one-cycle pulse, live byte present; no backpressure.
- live_data  in  8  live byte.
- patch_req  in  1  patch source has a byte; held until `patch_ack`.
- patch_data  in  8  patch byte.
- patch_last  in  1  current patch byte ends the message.
- patch_ack  out  1  one-cycle pulse, patch byte issued.
- auto_req, auto_data[8], auto_last  in  auto source; same rules as patch.
- auto_ack  out  1  one-cycle pulse, auto byte issued.
- clr_err  in  1  clears sticky error flags.
- byteready  out  1  one-cycle issue pulse.
- midi_in_data  out  8  issued byte; held until next issue.
- midibyte_nr  out  8  byte index within message; held until next issue.
- dec_sysex_data_patch_send  out  1  patch source owns the path.
- auto_syx_cmd  out  1  auto source owns the path.
- busy  out  1  state is not IDLE, or live FIFO is not empty.
- live_ovf  out  1  sticky: live byte dropped.
- lock_timeout  out  1  sticky: lock revoked.

## Operation
- Live FIFO: push on `live_valid`.
  - Full with no pop in the same cycle: byte dropped, `live_ovf`=1.
  - Full with a pop in the same cycle: push accepted.
- States:
  - IDLE: arbitrate; on a winner -> ISSUE.
  - ISSUE: one cycle. `byteready`=1, outputs load, the ack (or FIFO pop) fires. -> GAP.
  - GAP: GAP-1 cycles. In the last cycle, arbitrate; a winner -> ISSUE, no winner -> IDLE.
- Arbitration when unlocked: fixed priority live FIFO non-empty > patch_req > auto_req.
- Arbitration when locked: only the lock owner is eligible.
- Lock:
  - Set at issue of a patch/auto byte whose `*_last`=0.
  - Cleared at the end of the GAP following the issue of a byte with `*_last`=1.
  - Live bytes never lock.
  - Live bytes arriving during a lock queue in the FIFO.
- Owner flags: `dec_sysex_data_patch_send`/`auto_syx_cmd` rise in the ISSUE cycle of the owner's byte. They fall after the GAP that follows the owner's final byte, or on timeout. At most one is high at a time.
- `midibyte_nr` rules:
  - Issued byte with bit7=1 gives 0.
  - Otherwise previous value + 1, saturating at 255.
  - The value is per-path, not per-source.
- Timeout:
  - A 16-bit counter counts cycles in IDLE/GAP-end while locked and the owner's req=0. It clears on issue.
  - At TIMEOUT: lock cleared, owner flag cleared, `lock_timeout`=1. Next cycle is IDLE.
- Sticky flags: cleared by `clr_err`. A set in the same cycle as `clr_err` wins.

## Timing
- Reset (async) values: state IDLE, FIFO empty, lock clear, all counters 0. All outputs 0: `byteready`, acks, `midi_in_data`, `midibyte_nr`, owner flags, `busy`, `live_ovf`, `lock_timeout`.
- Reset mid-message discards the FIFO and the lock. No ack is issued for a byte pending at reset.
- Latency:
  - A request visible at edge k with the block in IDLE gives `byteready` in cycle k+1.
  - A live byte pushed at edge k into an empty FIFO in IDLE gives `byteready` in cycle k+2 (one cycle for the FIFO write).
- Spacing: consecutive `byteready` pulses are exactly GAP cycles apart when the next request is already pending; never fewer.
- Each ack coincides with the `byteready` of that source's byte. A source may change `*_data`/`*_last` and may drop `*_req` in the cycle after its ack.
- `*_req` must not be withdrawn before ack. If withdrawn, the request is ignored; no error is raised.

## Test plan
- Single live byte 0x90 after reset -> `byteready` at +2, `midi_in_data`=0x90, `midibyte_nr`=0, owner flags 0.
- Live 0x90,0x3C,0x64 pushed every cycle (GAP=4) -> three pulses 4 cycles apart, nr=0,1,2. No overflow with FIFO_DEPTH=4.
- Patch message F0,43,10,F7 (last on F7) with live 0x80 pushed mid-message:
  - Required: patch bytes issued contiguously, `dec_sysex_data_patch_send` high from first issue to GAP end after F7.
  - Required: then 0x80 issued with nr=0.
- Patch and auto requesting simultaneously from IDLE -> patch wins. Auto is served only after patch's last byte, with `auto_syx_cmd` following.
- Patch locks with F0, then drops req for TIMEOUT cycles -> `lock_timeout`=1, flag drops, pending auto_req is then served. `clr_err` pulse -> flag 0.
- Six live pushes in one burst with FIFO_DEPTH=4 while auto is locked:
  - Required: `live_ovf`=1, four bytes delivered in order after unlock.
  - Required: reset asserted mid-burst returns every output to 0 asynchronously.
